// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED request arbiter.
package led_arb_pkg;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OWN  = 2'd2
  } state_e;

  // Active-low LED drive value for "all off".
  localparam logic [2:0] LED_OFF_N = 3'b111;

  // Active-high color codes {R,G,B}.
  localparam logic [2:0] COL_R = 3'b100;
  localparam logic [2:0] COL_G = 3'b010;
  localparam logic [2:0] COL_B = 3'b001;

endpackage

// File: rtl/led_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module led_prio_enc #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [N_REQ-1:0] onehot
);

  // Scan from the top down so the lowest set index is written last and wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid  = 1'b1;
        index  = IDX_W'(i);
        onehot = N_REQ'(1) << i;
      end
    end
  end

endmodule

// File: rtl/led_req_arbiter.sv
// Fixed-priority arbiter sharing one active-low RGB LED between N_REQ
// requesters, with a minimum display hold time after every new grant.
module led_req_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2500000,
  parameter int CNT_W       = 22
) (
  input  logic               REFCLK_3B0,
  input  logic               reset_synched,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] color,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [2:0]         led_n,
  output logic               switch_p
);

  localparam int              IDX_W    = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);

  // Arbitration state
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [2:0]         col_q, col_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Registered outputs
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [2:0]         led_n_q, led_n_d;
  logic               switch_p_q, switch_p_d;

  // Encoder results and per-owner views
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [2:0]         pick_col;
  logic               owner_req;
  logic [2:0]         owner_col;
  logic               take;

  led_prio_enc #(
    .N_REQ (N_REQ)
  ) u_prio_enc (
    .req    (req),
    .valid  (pick_vld),
    .index  (pick_idx),
    .onehot (pick_oh)
  );

  assign pick_col  = color[3*int'(pick_idx) +: 3];
  assign owner_req = req[owner_q];
  assign owner_col = color[3*int'(owner_q) +: 3];

  // State register: synchronous reset overrides all activity, including mid-hold.
  always_ff @(posedge REFCLK_3B0) begin
    if (reset_synched) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= IDLE;
      owner_q    <= '0;
      col_q      <= 3'b000;
      cnt_q      <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      led_n_q    <= LED_OFF_N;
      switch_p_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      led_n_q    <= led_n_d;
      switch_p_q <= switch_p_d;
    end
  end

  // Next-state logic: hold lockout, exit evaluation, preemption and release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    take    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_vld) take = 1'b1;
      end
      HOLD: begin
        // Owner cannot be preempted; color follows the owner only while it requests.
        if (owner_req) col_d = owner_col;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!pick_vld) begin
          state_d = IDLE;
        end else if (pick_idx != owner_q) begin
          take = 1'b1;
        end else begin
          state_d = OWN;
        end
      end
      OWN: begin
        // pick differs from owner on either a higher-priority request or owner release.
        if (!pick_vld) begin
          state_d = IDLE;
        end else if (pick_idx != owner_q) begin
          take = 1'b1;
        end else begin
          col_d = owner_col;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = HOLD;
      owner_d = pick_idx;
      col_d   = pick_col;
      cnt_d   = HOLD_LD;
    end
  end

  // Output logic: derive the next registered outputs from the next state.
  always_comb begin
    switch_p_d = take;
    busy_d     = (state_d != IDLE);
    led_n_d    = busy_d ? ~col_d : LED_OFF_N;
    grant_d    = '0;
    if (busy_d) grant_d = take ? pick_oh : grant_q;
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign led_n    = led_n_q;
  assign switch_p = switch_p_q;

endmodule

// File: tb/tb_led_req_arbiter.sv
// Self-checking bench for led_req_arbiter: directed scenarios plus
// randomized traffic against an age-based reference model.
module tb_led_req_arbiter;
  import led_arb_pkg::*;

  localparam int N    = 4;
  localparam int HOLD = 4;

  logic          clk;
  logic          reset_synched;
  logic [N-1:0]  req;
  logic [3*N-1:0] color;
  logic [N-1:0]  grant;
  logic          busy;
  logic [2:0]    led_n;
  logic          switch_p;
  logic [8:0]    obs;
  logic [8:0]    exp_v;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 = idle) and cycles since the grant.
  int         m_owner;
  int         m_age;
  logic [2:0] m_col;
  logic       m_sw;

  led_req_arbiter #(
    .N_REQ       (N),
    .HOLD_CYCLES (HOLD),
    .CNT_W       (3)
  ) dut (
    .REFCLK_3B0    (clk),
    .reset_synched (reset_synched),
    .req           (req),
    .color         (color),
    .grant         (grant),
    .busy          (busy),
    .led_n         (led_n),
    .switch_p      (switch_p)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  assign obs = {grant, busy, led_n, switch_p};

  function automatic logic [8:0] pk(input logic [3:0] g, input logic b,
                                     input logic [2:0] l, input logic s);
    return {g, b, l, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_synched = 1'b1;
    req           = '0;
    color         = '0;
    tick();
    reset_synched = 1'b0;
  endtask

  task automatic m_grant(input int pick, input logic [3*N-1:0] cl);
    m_owner = pick;
    m_age   = 0;
    m_col   = cl[3*pick +: 3];
    m_sw    = 1'b1;
  endtask

  // A granted owner is locked for HOLD cycles; afterwards it keeps the LED
  // only while it is the lowest requesting index.
  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [3*N-1:0] cl);
    int pick;
    pick = -1;
    for (int i = N - 1; i >= 0; i--) if (rq[i]) pick = i;
    m_sw = 1'b0;
    if (r) begin
      m_owner = -1;
      m_col   = 3'b000;
    end else if (m_owner < 0) begin
      if (pick >= 0) m_grant(pick, cl);
    end else begin
      if (m_age < HOLD) m_age++;
      if (m_age < HOLD) begin
        if (rq[m_owner]) m_col = cl[3*m_owner +: 3];
      end else if (pick < 0) begin
        m_owner = -1;
      end else if (pick != m_owner) begin
        m_grant(pick, cl);
      end else begin
        m_col = cl[3*m_owner +: 3];
      end
    end
  endtask

  function automatic logic [8:0] model_out();
    if (m_owner < 0) return pk(4'b0000, 1'b0, LED_OFF_N, m_sw);
    return pk(4'(1 << m_owner), 1'b1, ~m_col, m_sw);
  endfunction

  task automatic test_reset();
    reset_synched = 1'b1;
    req           = 4'hF;
    color         = {4{COL_G}};
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = pk(4'b0000, 1'b0, 3'b111, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_during[%0d]: got %b want %b (grant,busy,led_n,switch_p)", i, obs, exp_v);
      end
    end
    reset_synched = 1'b0;
    req           = '0;
    tick();
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_after: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
  endtask

  task automatic test_hold_block();
    do_reset();
    color[8:6] = COL_R;
    req        = 4'b0100;
    tick();
    exp_v = pk(4'b0100, 1'b1, 3'b011, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL first_grant: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
    color[2:0] = COL_G;
    req        = 4'b0101;
    for (int i = 2; i <= 4; i++) begin
      tick();
      exp_v = pk(4'b0100, 1'b1, 3'b011, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL hold_no_preempt[%0d]: got %b want %b (grant,busy,led_n,switch_p)", i, obs, exp_v);
      end
    end
    tick();
    exp_v = pk(4'b0001, 1'b1, 3'b101, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL hold_expiry_switch: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
  endtask

  task automatic test_release_in_hold();
    do_reset();
    color[5:3] = COL_B;
    req        = 4'b0010;
    tick();
    exp_v = pk(4'b0010, 1'b1, 3'b110, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL release_grant: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
    req        = '0;
    color[5:3] = COL_R;
    for (int i = 2; i <= 4; i++) begin
      tick();
      exp_v = pk(4'b0010, 1'b1, 3'b110, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL release_frozen[%0d]: got %b want %b (grant,busy,led_n,switch_p)", i, obs, exp_v);
      end
    end
    tick();
    exp_v = pk(4'b0000, 1'b0, 3'b111, 1'b0);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL release_idle: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    color[11:9] = COL_R | COL_G;
    req         = 4'b1000;
    tick();
    exp_v = pk(4'b1000, 1'b1, 3'b001, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL own_grant: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
    for (int i = 2; i <= 7; i++) begin
      tick();
      exp_v = pk(4'b1000, 1'b1, 3'b001, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL own_steady[%0d]: got %b want %b (grant,busy,led_n,switch_p)", i, obs, exp_v);
      end
    end
    color[5:3] = COL_B;
    req        = 4'b1010;
    tick();
    exp_v = pk(4'b0010, 1'b1, 3'b110, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL own_preempt: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
    color[8:6] = COL_R;
    req        = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_v = pk(4'b0010, 1'b1, 3'b110, 1'b0);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL lower_no_preempt[%0d]: got %b want %b (grant,busy,led_n,switch_p)", i, obs, exp_v);
      end
    end
    color[5:3] = COL_G;
    tick();
    exp_v = pk(4'b0010, 1'b1, 3'b101, 1'b0);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL own_color_track: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
  endtask

  task automatic test_tie_and_reset();
    do_reset();
    color = {COL_B, COL_R, COL_B, COL_G};
    req   = 4'hF;
    tick();
    exp_v = pk(4'b0001, 1'b1, 3'b101, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL tie_lowest: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
    tick();
    tick();
    reset_synched = 1'b1;
    tick();
    exp_v = pk(4'b0000, 1'b0, 3'b111, 1'b0);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_hold: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
    reset_synched = 1'b0;
    tick();
    exp_v = pk(4'b0001, 1'b1, 3'b101, 1'b1);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL regrant_after_reset: got %b want %b (grant,busy,led_n,switch_p)", obs, exp_v);
    end
  endtask

  task automatic test_random();
    logic           r;
    logic [N-1:0]   rq;
    logic [3*N-1:0] cl;
    int             b;
    do_reset();
    model_step(1'b1, '0, '0);
    rq = '0;
    cl = '0;
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(99) == 0);
      if ($urandom_range(3) == 0) begin
        b     = int'($urandom_range(N - 1));
        rq[b] = ~rq[b];
      end
      if ($urandom_range(2) == 0) begin
        b              = int'($urandom_range(N - 1));
        cl[3*b +: 3]   = 3'($urandom);
      end
      reset_synched = r;
      req           = rq;
      color         = cl;
      tick();
      model_step(r, rq, cl);
      exp_v = model_out();
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b want %b (grant,busy,led_n,switch_p) req=%b", c, obs, exp_v, rq);
      end
    end
    reset_synched = 1'b0;
  endtask

  initial begin
    reset_synched = 1'b1;
    req           = '0;
    color         = '0;
    m_owner       = -1;
    m_age         = 0;
    m_col         = 3'b000;
    m_sw          = 1'b0;
    test_reset();
    test_hold_block();
    test_release_in_hold();
    test_preempt();
    test_tie_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_req_arbiter.md
Name: led_req_arbiter

Overview:
- Shares one active-low RGB LED between N_REQ requesters (heartbeat counter, push-button logic, error flags, etc.).
- Fixed-priority arbitration: index 0 is the highest priority.
- A minimum display hold time prevents flicker and color thrash.
- Sits between the requester logic and the top-level LEDxR/G/B pins, in the 25 MHz REFCLK_3B0 domain. Its reset is the synchronized reset_synched.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- HOLD_CYCLES, 2500000: minimum cycles a newly granted owner stays displayed (100 ms at 25 MHz). Must be ≥1.
- CNT_W, 22: hold counter width. Must satisfy 2**CNT_W > HOLD_CYCLES-1.

Ports:
- REFCLK_3B0  in  1: the single clock, 25 MHz.
- reset_synched  in  1: synchronous, active-high reset.
- req  in  N_REQ: per-requester display request, level.
- color  in  3*N_REQ: requester i color at [3i+2:3i]. Bit2=R, bit1=G, bit0=B; 1 = lit (active high).
- grant  out  N_REQ: one-hot current owner, registered. All-zero when idle.
- busy  out  1: the LED is owned (state != IDLE), registered.
- led_n  out  3: active-low LED drive {R,G,B}, registered. 3'b111 = off.
- switch_p  out  1: one-cycle pulse on every new grant (IDLE→owner or owner change).

Behaviour:
- Interface: one clock, REFCLK_3B0. Reset reset_synched is synchronous and active-high.
- Reset: state=IDLE, grant=0, busy=0, led_n=3'b111, switch_p=0, hold counter=0, latched color=3'b000. Reset overrides all activity, including mid-HOLD. Outputs show reset values on the cycle after the reset edge.
- Latency: a request sampled at edge t produces grant/led_n/switch_p at edge t+1 (1 cycle).
- pick = lowest set index of req. Ties between simultaneous requests go to the lowest index.
- Grant action:
  - owner <= pick
  - latched color <= color[pick]
  - counter <= HOLD_CYCLES-1
  - state <= HOLD
  - switch_p <= 1
- IDLE: if any req, perform the grant action. Otherwise stay; led_n=111.
- HOLD: owner cannot be preempted, even by a higher priority.
  - If the owner's req=1: latched color tracks color[owner] every cycle.
  - If the owner's req=0: latched color freezes at its last value and the LED stays lit.
  - If counter != 0: counter decrements.
  - If counter == 0, exit evaluation at this edge:
    - owner req=1 and pick==owner → state OWN, no switch_p.
    - pick exists and pick != owner → grant action for pick.
    - no req → IDLE, grant=0, led_n=111.
  - Net effect: a new grant is displayed for exactly HOLD_CYCLES cycles minimum.
- OWN:
  - A higher-priority req (pick < owner) → grant action immediately (preemption).
  - Owner req drops → grant action for pick if any, else IDLE.
  - Otherwise stay; latched color tracks color[owner].
- Output mapping:
  - led_n <= ~latched color in HOLD/OWN, 3'b111 in IDLE.
  - A color value of 3'b000 displays as off but still holds ownership.
- Lower-priority requests never preempt; they are served only when the owner releases.
- switch_p is 0 in every cycle without a grant action.

Decomposition:
- Package led_arb_pkg:
  - state enum {IDLE, HOLD, OWN}
  - LED_OFF_N = 3'b111
  - color constants COL_R=3'b100, COL_G=3'b010, COL_B=3'b001
- Sub-module led_prio_enc: combinational lowest-index-first encoder, N_REQ parameter. Outputs valid, index, onehot.
- The arbiter FSM, hold counter and output registers stay in led_req_arbiter.

Test Plan (N_REQ=4, HOLD_CYCLES=4):
1. Assert reset 2 cycles with req=4'hF → during and 1 cycle after: led_n=3'b111, grant=0, busy=0, switch_p=0.
2. req[2]=1, color2=R at edge 0 → edge 1: grant=4'b0100, led_n=3'b011, busy=1, switch_p=1. Edge 2: switch_p=0.
3. Continuing 2, req[0]=1 color0=G from edge 2 → grant stays 0100 through edge 4. Edge 5: grant=0001, led_n=3'b101, switch_p=1.
4. req[1]=1 color1=B at edge 0, dropped at edge 2 → led_n=3'b110 edges 1–4. Edge 5: led_n=3'b111, grant=0, busy=0.
5. req[3] held alone → OWN from edge 5 with grant=1000. req[1] at edge 8 → edge 9: grant=0010, switch_p=1. Then req[2] at edge 10 → no change until hold expiry.
6. req=4'hF simultaneously → grant=0001. Reset mid-HOLD at edge 3 → edge 4: led_n=3'b111, grant=0, state IDLE.
